gpr_write_arbiter: RTL and testbench

Shares the two GPR file write ports (A and B) between `NUM_REQ` write-back requesters (ALU, load unit, mul/div, I/O). Each cycle it grants up to two requests in round-robin order and never grants two writes to the same register in one cycle. Granted writes go through a one-cycle output register that drives the write-side signals of the GPR file interface (`wa_sel/wa_wr/wa`, `wb_sel/wb_wr/wb`) from the processor side.

---
 rtl/pu_types.sv | 24 ++
 rtl/gpr_file_if.sv | 35 +++
 rtl/rr_two_pick.sv | 63 ++++++
 rtl/gpr_write_arbiter.sv | 106 ++++++++++
 tb/tb_gpr_write_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pu_types.sv
// Pu_types: processing-unit types shared by the GPR file and its write-side
// arbitration.
//   Reg_index     : GPR index (32 registers).
//   Word          : data word carried by the GPR file.
//   Gpr_write_req : register index plus data, one pending write.
//   idx_width()   : index width for an N-entry vector (never 0).
package Pu_types;

  localparam int REG_INDEX_W = 5;
  localparam int WORD_W      = 32;

  typedef logic [REG_INDEX_W-1:0] Reg_index;
  typedef logic [WORD_W-1:0]      Word;

  typedef struct packed {
    Reg_index sel;
    Word      data;
  } Gpr_write_req;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// Gpr_file_if: connects the processor to the GPR file.
//   Read side  : ra_sel/rb_sel (processor -> file), ra/rb (file -> processor).
//   Write side : wa_sel/wa_wr/wa and wb_sel/wb_wr/wb (processor -> file).
// The processor modport is shared by several processor blocks; each block
// drives only the fields it owns.
interface Gpr_file_if;
  import Pu_types::*;

  Reg_index ra_sel;
  Reg_index rb_sel;
  Word      ra;
  Word      rb;

  Reg_index wa_sel;
  logic     wa_wr;
  Word      wa;
  Reg_index wb_sel;
  logic     wb_wr;
  Word      wb;

  modport processor (
    output ra_sel, rb_sel,
    input  ra, rb,
    output wa_sel, wa_wr, wa,
    output wb_sel, wb_wr, wb
  );

  modport gpr_file (
    input  ra_sel, rb_sel,
    output ra, rb,
    input  wa_sel, wa_wr, wa,
    input  wb_sel, wb_wr, wb
  );

endinterface

// File: rtl/rr_two_pick.sv
// rr_two_pick: combinational round-robin picker for two write ports.
//   valid_i    : requesters with a pending write.
//   sel_i      : target register per requester.
//   ptr_i      : highest-priority requester (must be < NUM_REQ).
//   grant_a_o  : one-hot port A grant (first valid requester from ptr_i).
//   grant_b_o  : one-hot port B grant (next valid requester with a different
//                target register than the port A winner).
//   last_idx_o : index of the last granted requester (0 when nothing granted).
module rr_two_pick
  import Pu_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  Reg_index           sel_i [NUM_REQ],
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_a_o,
  output logic [NUM_REQ-1:0] grant_b_o,
  output logic [IDX_W-1:0]   last_idx_o
);

  logic             found_a;
  logic             found_b;
  Reg_index         sel_a;
  logic [IDX_W:0]   idx_wide;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_a_o  = '0;
    grant_b_o  = '0;
    last_idx_o = '0;
    found_a    = 1'b0;
    found_b    = 1'b0;
    sel_a      = '0;
    idx_wide   = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr+k cannot overflow before the modulo wrap,
      // which also covers non-power-of-two requester counts.
      idx_wide = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (idx_wide >= (IDX_W+1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (IDX_W+1)'(NUM_REQ);
      end
      idx = idx_wide[IDX_W-1:0];
      if (valid_i[idx]) begin
        if (!found_a) begin
          found_a        = 1'b1;
          sel_a          = sel_i[idx];
          grant_a_o[idx] = 1'b1;
          last_idx_o     = idx;
        end else if (!found_b && (sel_i[idx] != sel_a)) begin
          // Same-register requesters are skipped, not blocking: a later
          // requester with a different target can still take port B.
          found_b        = 1'b1;
          grant_b_o[idx] = 1'b1;
          last_idx_o     = idx;
        end
      end
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: shares the two GPR write ports between NUM_REQ
// write-back requesters, up to two grants per cycle in round-robin order,
// never two writes to the same register in one cycle.
//   clk, reset : clock, asynchronous active-high reset.
//   hold       : suppresses all grants; requests stay pending.
//   req_valid  : per-requester write request.
//   req_sel    : per-requester target register.
//   req_data   : per-requester write data.
//   req_ready  : per-requester grant (combinational).
//   gpr        : GPR file interface; only the write fields are driven here,
//                one cycle after the grant.
module gpr_write_arbiter
  import Pu_types::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [NUM_REQ-1:0] req_valid,
  input  Reg_index           req_sel [NUM_REQ],
  input  Word                req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  Gpr_file_if.processor      gpr
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] grant_a;
  logic [NUM_REQ-1:0] grant_b;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  Gpr_write_req       req_pkt [NUM_REQ];
  Gpr_write_req       win_a;
  Gpr_write_req       win_b;
  Gpr_write_req       wa_q;
  Gpr_write_req       wb_q;
  logic               wa_wr_q;
  logic               wb_wr_q;

  // Masking the picker input (rather than its outputs) keeps grants, ready
  // and the pointer update consistently silent during hold and reset.
  assign pick_valid = req_valid & {NUM_REQ{~(hold | reset)}};

  rr_two_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid_i    (pick_valid),
    .sel_i      (req_sel),
    .ptr_i      (rr_ptr_q),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .last_idx_o (last_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_ready[gi] = grant_a[gi] | grant_b[gi];
    assign req_pkt[gi]   = {req_sel[gi], req_data[gi]};
  end

  // One-hot grants turn the port muxes into plain AND-OR trees.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_a[i]) win_a = win_a | req_pkt[i];
      if (grant_b[i]) win_b = win_b | req_pkt[i];
    end
  end

  // Port B never grants without port A, so any grant shows up on grant_a.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant_a) begin
      rr_ptr_d = (last_idx == IDX_W'(NUM_REQ-1)) ? '0 : last_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      wa_wr_q  <= 1'b0;
      wb_wr_q  <= 1'b0;
      wa_q     <= '0;
      wb_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wa_wr_q  <= |grant_a;
      wb_wr_q  <= |grant_b;
      // Index/data registers hold their last value while no write is issued.
      if (|grant_a) wa_q <= win_a;
      if (|grant_b) wb_q <= win_b;
    end
  end

  assign gpr.wa_wr  = wa_wr_q;
  assign gpr.wa_sel = wa_q.sel;
  assign gpr.wa     = wa_q.data;
  assign gpr.wb_wr  = wb_wr_q;
  assign gpr.wb_sel = wb_q.sel;
  assign gpr.wb     = wb_q.data;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed testbench for gpr_write_arbiter (NUM_REQ = 4).
module tb_gpr_write_arbiter;
  import Pu_types::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         hold;
  logic [N-1:0] req_valid;
  Reg_index     req_sel [N];
  Word          req_data [N];
  logic [N-1:0] req_ready;

  int checks = 0;
  int errors = 0;

  Gpr_file_if gpr_if ();

  // Read side belongs to other processor blocks; tie it off here.
  assign gpr_if.ra_sel = '0;
  assign gpr_if.rb_sel = '0;
  assign gpr_if.ra     = '0;
  assign gpr_if.rb     = '0;

  gpr_write_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gpr       (gpr_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic awr, input logic [4:0] asel,
                           input logic [31:0] a, input logic bwr);
    check_eq({tag, ".wa_wr"},  gpr_if.wa_wr,  awr);
    check_eq({tag, ".wa_sel"}, gpr_if.wa_sel, asel);
    check_eq({tag, ".wa"},     gpr_if.wa,     a);
    check_eq({tag, ".wb_wr"},  gpr_if.wb_wr,  bwr);
  endtask

  logic [N-1:0] exp_ready;
  int           wait_cnt [N];
  int           max_wait;

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    for (int r = 0; r < N; r++) begin
      req_sel[r]  = '0;
      req_data[r] = '0;
    end
    repeat (2) tick();

    // Reset state; ready stays low under reset even with every request valid.
    req_valid = 4'hF;
    #1;
    check_eq("rst.ready", req_ready, 4'h0);
    check_out("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("rst.wb_sel", gpr_if.wb_sel, 5'd0);
    check_eq("rst.wb", gpr_if.wb, 32'h0);
    check_eq("rst.ptr", dut.rr_ptr_q, 2'd0);
    req_valid = '0;
    reset     = 1'b0;
    tick();

    // Single request from requester 2.
    req_valid   = 4'b0100;
    req_sel[2]  = 5'd5;
    req_data[2] = 32'hDEADBEEF;
    #1;
    check_eq("single.ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_out("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    check_eq("single.ptr", dut.rr_ptr_q, 2'd3);

    // Requester 3 alone: pointer wraps from 3 to 0.
    req_valid   = 4'b1000;
    req_sel[3]  = 5'd9;
    req_data[3] = 32'h33;
    #1;
    check_eq("wrap.ready", req_ready, 4'b1000);
    tick();
    check_eq("wrap.ptr", dut.rr_ptr_q, 2'd0);

    // Dual grant across the index boundary.
    req_valid   = 4'b1001;
    req_sel[0]  = 5'd1;
    req_data[0] = 32'hA0;
    req_sel[3]  = 5'd2;
    req_data[3] = 32'hA3;
    #1;
    check_eq("dual.ready", req_ready, 4'b1001);
    tick();
    req_valid = '0;
    check_out("dual", 1'b1, 5'd1, 32'hA0, 1'b1);
    check_eq("dual.wb_sel", gpr_if.wb_sel, 5'd2);
    check_eq("dual.wb", gpr_if.wb, 32'hA3);
    check_eq("dual.ptr", dut.rr_ptr_q, 2'd0);

    // Move pointer to 1 via requester 0.
    req_valid  = 4'b0001;
    req_sel[0] = 5'd4;
    tick();
    check_eq("mv.ptr", dut.rr_ptr_q, 2'd1);

    // Same-index conflict: 1 and 2 both target r7.
    req_valid   = 4'b0110;
    req_sel[1]  = 5'd7;
    req_data[1] = 32'h11;
    req_sel[2]  = 5'd7;
    req_data[2] = 32'h22;
    #1;
    check_eq("conf.ready0", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    check_out("conf0", 1'b1, 5'd7, 32'h11, 1'b0);
    check_eq("conf0.ptr", dut.rr_ptr_q, 2'd2);
    check_eq("conf.ready1", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_out("conf1", 1'b1, 5'd7, 32'h22, 1'b0);
    check_eq("conf1.ptr", dut.rr_ptr_q, 2'd3);

    // Idle cycle: write strobes drop, index/data hold.
    tick();
    check_out("idle", 1'b0, 5'd7, 32'h22, 1'b0);
    check_eq("idle.ptr", dut.rr_ptr_q, 2'd3);

    // Bring pointer to 0 via requester 3.
    req_valid = 4'b1000;
    tick();
    check_eq("mv2.ptr", dut.rr_ptr_q, 2'd0);

    // Fairness: all four valid, distinct targets, for 8 cycles.
    for (int r = 0; r < N; r++) begin
      req_sel[r]  = 5'(r + 1);
      req_data[r] = 32'h100 + 32'(r);
      wait_cnt[r] = 0;
    end
    max_wait  = 0;
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_ready = (i % 2 == 0) ? 4'b0011 : 4'b1100;
      check_eq($sformatf("fair%0d.ready", i), req_ready, exp_ready);
      for (int r = 0; r < N; r++) begin
        if (req_ready[r]) wait_cnt[r] = 0;
        else              wait_cnt[r]++;
        if (wait_cnt[r] > max_wait) max_wait = wait_cnt[r];
      end
      tick();
      check_eq($sformatf("fair%0d.wa_sel", i), gpr_if.wa_sel, (i % 2 == 0) ? 5'd1 : 5'd3);
      check_eq($sformatf("fair%0d.wb_sel", i), gpr_if.wb_sel, (i % 2 == 0) ? 5'd2 : 5'd4);
      check_eq($sformatf("fair%0d.wa", i), gpr_if.wa, (i % 2 == 0) ? 32'h100 : 32'h102);
    end
    check_eq("fair.nostarve", (max_wait < N), 1'b1);
    check_eq("fair.ptr", dut.rr_ptr_q, 2'd0);

    // Hold for 3 cycles with two pending requests.
    hold        = 1'b1;
    req_valid   = 4'b0110;
    req_sel[1]  = 5'd6;
    req_data[1] = 32'h61;
    req_sel[2]  = 5'd8;
    req_data[2] = 32'h82;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("hold%0d.ready", i), req_ready, 4'b0000);
      tick();
      check_eq($sformatf("hold%0d.wa_wr", i), gpr_if.wa_wr, 1'b0);
      check_eq($sformatf("hold%0d.wb_wr", i), gpr_if.wb_wr, 1'b0);
      check_eq($sformatf("hold%0d.ptr", i), dut.rr_ptr_q, 2'd0);
    end
    hold = 1'b0;
    #1;
    check_eq("rel.ready", req_ready, 4'b0110);
    tick();
    req_valid = '0;
    check_out("rel", 1'b1, 5'd6, 32'h61, 1'b1);
    check_eq("rel.wb_sel", gpr_if.wb_sel, 5'd8);
    check_eq("rel.wb", gpr_if.wb, 32'h82);
    check_eq("rel.ptr", dut.rr_ptr_q, 2'd3);

    // Reset mid-operation: outputs clear without a clock edge.
    reset     = 1'b1;
    req_valid = 4'b0001;
    #1;
    check_out("arst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("arst.ptr", dut.rr_ptr_q, 2'd0);
    check_eq("arst.ready", req_ready, 4'b0000);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    tick();
    check_out("post", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("post.wb_sel", gpr_if.wb_sel, 5'd0);
    check_eq("post.ptr", dut.rr_ptr_q, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
